// File: rtl/mem_responder.sv
// Behavioural MemBus main-memory responder: in-order writes, fixed-latency read pipeline,
// saturating read/write activity counters and a sticky illegal-op flag.
module mem_responder #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_rst,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic                  proto_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        OP_INVALID = 2'd0,
        OP_READ    = 2'd1,
        OP_WRITE   = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    op_e op;
    assign op = op_e'(req_op);

    logic [DATA_WIDTH-1:0]   mem_q  [DEPTH];
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] vld_d;
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_d [READ_LATENCY];
    logic [CNT_WIDTH-1:0]    rdCnt_q;
    logic [CNT_WIDTH-1:0]    wrCnt_q;
    logic                    protoErr_q;

    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
        $error("mem_responder: READ_LATENCY must be within 1..8");
    end

    // Stage 0 takes a snapshot of the word before this edge's write, so a read never
    // sees a write sampled at the same or a later edge.
    always_comb begin
        for (int k = 0; k < READ_LATENCY; k++) begin
            vld_d[k]  = 1'b0;
            data_d[k] = data_q[k];
        end
        vld_d[0]  = (op == OP_READ);
        data_d[0] = mem_q[req_addr];
        for (int k = 1; k < READ_LATENCY; k++) begin
            vld_d[k]  = vld_q[k-1];
            data_d[k] = data_q[k-1];
        end
    end

    // Stage data only loads behind a valid bit, so the last stage doubles as the
    // held rsp_data value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int k = 0; k < READ_LATENCY; k++) data_q[k] <= '0;
            vld_q      <= '0;
            rdCnt_q    <= '0;
            wrCnt_q    <= '0;
            protoErr_q <= 1'b0;
        end else if (bus_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int k = 0; k < READ_LATENCY; k++) data_q[k] <= '0;
            vld_q      <= '0;
            rdCnt_q    <= '0;
            wrCnt_q    <= '0;
            protoErr_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                if (vld_d[k]) data_q[k] <= data_d[k];
            end
            if (op == OP_WRITE) mem_q[req_addr] <= req_data;
            if (op == OP_READ && rdCnt_q != '1) rdCnt_q <= rdCnt_q + CNT_WIDTH'(1);
            if (op == OP_WRITE && wrCnt_q != '1) wrCnt_q <= wrCnt_q + CNT_WIDTH'(1);
            if (op == OP_ILLEGAL) protoErr_q <= 1'b1;
        end
    end

    assign rsp_vld   = vld_q[READ_LATENCY-1];
    assign rsp_data  = data_q[READ_LATENCY-1];
    assign rd_cnt    = rdCnt_q;
    assign wr_cnt    = wrCnt_q;
    assign proto_err = protoErr_q;

    flushedReadSilent: assert property (@(posedge clk) disable iff (!rst_n) bus_rst |=> !rsp_vld)
        else $error("mem_responder: response emitted for a flushed read");

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 2 / 16-bit counters and latency 1 / 4-bit
// counters) share stimulus and are compared against a queue-based memory model.
module tb_mem_responder;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int CW_A  = 16;
    localparam int CW_B  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          busRst;
    logic [1:0]    reqOp;
    logic [AW-1:0] reqAddr;
    logic [DW-1:0] reqData;

    logic            rspVldA, rspVldB;
    logic [DW-1:0]   rspDataA, rspDataB;
    logic [CW_A-1:0] rdCntA, wrCntA;
    logic [CW_B-1:0] rdCntB, wrCntB;
    logic            protoErrA, protoErrB;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_A), .CNT_WIDTH(CW_A)) dutA (
        .clk(clk), .rst_n(rst_n), .bus_rst(busRst), .req_op(reqOp), .req_addr(reqAddr),
        .req_data(reqData), .rsp_vld(rspVldA), .rsp_data(rspDataA), .rd_cnt(rdCntA),
        .wr_cnt(wrCntA), .proto_err(protoErrA)
    );

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_B), .CNT_WIDTH(CW_B)) dutB (
        .clk(clk), .rst_n(rst_n), .bus_rst(busRst), .req_op(reqOp), .req_addr(reqAddr),
        .req_data(reqData), .rsp_vld(rspVldB), .rsp_data(rspDataB), .rd_cnt(rdCntB),
        .wr_cnt(wrCntB), .proto_err(protoErrB)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          pendA[$];
    rsp_t          pendB[$];
    logic [DW-1:0] modelMem [1<<AW];
    int            edgeNo;
    int            rdCount;
    int            wrCount;
    logic          errModel;
    logic          expVldA, expVldB;
    logic [DW-1:0] expDataA, expDataB;
    logic [CW_A-1:0] expRdA, expWrA;
    logic [CW_B-1:0] expRdB, expWrB;

    int testsRun = 0;
    int failures = 0;

    function automatic int sat(input int c, input int w);
        int top = (1 << w) - 1;
        return (c > top) ? top : c;
    endfunction

    task automatic refreshCounters();
        expRdA = CW_A'(sat(rdCount, CW_A));
        expWrA = CW_A'(sat(wrCount, CW_A));
        expRdB = CW_B'(sat(rdCount, CW_B));
        expWrB = CW_B'(sat(wrCount, CW_B));
    endtask

    task automatic clearModel();
        foreach (modelMem[i]) modelMem[i] = '0;
        pendA.delete();
        pendB.delete();
        rdCount  = 0;
        wrCount  = 0;
        errModel = 1'b0;
        expVldA  = 1'b0;
        expVldB  = 1'b0;
        expDataA = '0;
        expDataB = '0;
        refreshCounters();
    endtask

    // Drives one request across one rising edge, advances the model, and returns #1 after the edge.
    task automatic step(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic brst);
        rsp_t r;
        reqOp   = op;
        reqAddr = addr;
        reqData = data;
        busRst  = brst;
        @(posedge clk);
        edgeNo++;
        if (brst) begin
            clearModel();
        end else if (op == 2'd1) begin
            r.data = modelMem[addr];
            r.due  = edgeNo + LAT_A - 1;
            pendA.push_back(r);
            r.due  = edgeNo + LAT_B - 1;
            pendB.push_back(r);
            rdCount++;
        end else if (op == 2'd2) begin
            modelMem[addr] = data;
            wrCount++;
        end else if (op == 2'd3) begin
            errModel = 1'b1;
        end
        expVldA = 1'b0;
        if (pendA.size() > 0 && pendA[0].due == edgeNo) begin
            r = pendA.pop_front();
            expVldA  = 1'b1;
            expDataA = r.data;
        end
        expVldB = 1'b0;
        if (pendB.size() > 0 && pendB[0].due == edgeNo) begin
            r = pendB.pop_front();
            expVldB  = 1'b1;
            expDataB = r.data;
        end
        refreshCounters();
        #1;
        reqOp  = 2'd0;
        busRst = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        busRst  = 1'b0;
        reqOp   = 2'd0;
        reqAddr = '0;
        reqData = '0;
        edgeNo  = 0;
        clearModel();
        #3;
        testsRun++; if (rspVldA !== 1'b0) begin failures++; $display("[TB] FAIL reset rsp_vld_a: got %b want 0", rspVldA); end
        testsRun++; if (rspDataA !== '0) begin failures++; $display("[TB] FAIL reset rsp_data_a: got %h want 00", rspDataA); end
        testsRun++; if (rdCntA !== '0) begin failures++; $display("[TB] FAIL reset rd_cnt_a: got %h want 0", rdCntA); end
        testsRun++; if (wrCntA !== '0) begin failures++; $display("[TB] FAIL reset wr_cnt_a: got %h want 0", wrCntA); end
        testsRun++; if (protoErrA !== 1'b0) begin failures++; $display("[TB] FAIL reset proto_err_a: got %b want 0", protoErrA); end
        testsRun++; if (rspVldB !== 1'b0) begin failures++; $display("[TB] FAIL reset rsp_vld_b: got %b want 0", rspVldB); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_latency();
        step(2'd1, 6'h05, 8'h00, 1'b0);
        testsRun++; if (rspVldA !== 1'b0) begin failures++; $display("[TB] FAIL latency early vld_a: got %b want 0", rspVldA); end
        testsRun++; if (rspVldB !== expVldB || rspDataB !== expDataB) begin failures++; $display("[TB] FAIL latency b: got %b/%h want %b/%h", rspVldB, rspDataB, expVldB, expDataB); end
        step(2'd0, 6'h00, 8'h00, 1'b0);
        testsRun++; if (rspVldA !== 1'b1 || rspDataA !== 8'h00) begin failures++; $display("[TB] FAIL latency pulse a: got %b/%h want 1/00", rspVldA, rspDataA); end
        testsRun++; if (rdCntA !== 16'd1) begin failures++; $display("[TB] FAIL latency rd_cnt_a: got %0d want 1", rdCntA); end
        step(2'd0, 6'h00, 8'h00, 1'b0);
        testsRun++; if (rspVldA !== 1'b0) begin failures++; $display("[TB] FAIL latency pulse width a: got %b want 0", rspVldA); end
    endtask

    task automatic test_write_then_read();
        logic [1:0] ops [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(ops[i], 6'h05, 8'hA7, 1'b0);
            testsRun++; if (rspVldA !== expVldA || rspDataA !== expDataA) begin failures++; $display("[TB] FAIL wr_rd step%0d a: got %b/%h want %b/%h", i, rspVldA, rspDataA, expVldA, expDataA); end
            testsRun++; if (rspVldB !== expVldB || rspDataB !== expDataB) begin failures++; $display("[TB] FAIL wr_rd step%0d b: got %b/%h want %b/%h", i, rspVldB, rspDataB, expVldB, expDataB); end
        end
        testsRun++; if (rspDataA !== 8'hA7) begin failures++; $display("[TB] FAIL wr_rd held data a: got %h want a7", rspDataA); end
        testsRun++; if (wrCntA !== expWrA || rdCntA !== expRdA) begin failures++; $display("[TB] FAIL wr_rd counters a: got %0d/%0d want %0d/%0d", wrCntA, rdCntA, expWrA, expRdA); end
    endtask

    task automatic test_read_then_write();
        logic [1:0] ops [5] = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0};
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(ops[i], 6'h05, 8'h3C, 1'b0);
            if (rspVldA === 1'b1) pulses++;
            testsRun++; if (rspVldA !== expVldA || rspDataA !== expDataA) begin failures++; $display("[TB] FAIL rd_wr step%0d a: got %b/%h want %b/%h", i, rspVldA, rspDataA, expVldA, expDataA); end
            testsRun++; if (rspVldB !== expVldB || rspDataB !== expDataB) begin failures++; $display("[TB] FAIL rd_wr step%0d b: got %b/%h want %b/%h", i, rspVldB, rspDataB, expVldB, expDataB); end
        end
        testsRun++; if (pulses !== 2) begin failures++; $display("[TB] FAIL rd_wr pulse count a: got %0d want 2", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) step(2'd2, AW'(i + 1), vals[i], 1'b0);
        for (int i = 0; i < 6; i++) begin
            step((i < 3) ? 2'd1 : 2'd0, AW'(i + 1), 8'h00, 1'b0);
            testsRun++; if (rspVldA !== expVldA || rspDataA !== expDataA) begin failures++; $display("[TB] FAIL b2b step%0d a: got %b/%h want %b/%h", i, rspVldA, rspDataA, expVldA, expDataA); end
            testsRun++; if (rspVldB !== expVldB || rspDataB !== expDataB) begin failures++; $display("[TB] FAIL b2b step%0d b: got %b/%h want %b/%h", i, rspVldB, rspDataB, expVldB, expDataB); end
        end
    endtask

    task automatic test_bus_rst_flush();
        step(2'd2, 6'h09, 8'h5A, 1'b0);
        step(2'd1, 6'h09, 8'h00, 1'b0);
        step(2'd2, 6'h0A, 8'hFF, 1'b1);
        testsRun++; if (rspVldA !== 1'b0) begin failures++; $display("[TB] FAIL flush vld_a: got %b want 0", rspVldA); end
        testsRun++; if (rdCntA !== '0 || wrCntA !== '0) begin failures++; $display("[TB] FAIL flush counters a: got %0d/%0d want 0/0", rdCntA, wrCntA); end
        for (int i = 0; i < 2; i++) begin
            step(2'd0, 6'h00, 8'h00, 1'b0);
            testsRun++; if (rspVldA !== 1'b0) begin failures++; $display("[TB] FAIL flush late vld_a: got %b want 0", rspVldA); end
        end
        step(2'd1, 6'h09, 8'h00, 1'b0);
        step(2'd1, 6'h0A, 8'h00, 1'b0);
        testsRun++; if (rspVldA !== expVldA || rspDataA !== 8'h00) begin failures++; $display("[TB] FAIL flush reread a: got %b/%h want %b/00", rspVldA, rspDataA, expVldA); end
        step(2'd0, 6'h00, 8'h00, 1'b0);
        testsRun++; if (rspVldA !== expVldA || rspDataA !== 8'h00) begin failures++; $display("[TB] FAIL flush ignored write a: got %b/%h want %b/00", rspVldA, rspDataA, expVldA); end
    endtask

    task automatic test_proto_err();
        step(2'd3, 6'h01, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            testsRun++; if (protoErrA !== errModel || protoErrB !== errModel) begin failures++; $display("[TB] FAIL proto_err sticky %0d: got %b/%b want %b", i, protoErrA, protoErrB, errModel); end
            step((i == 1) ? 2'd1 : 2'd2, AW'(i), 8'hC0, 1'b0);
        end
        rst_n = 1'b0;
        #2;
        testsRun++; if (protoErrA !== 1'b0 || rspVldA !== 1'b0 || rspDataA !== '0) begin failures++; $display("[TB] FAIL async reset a: got err=%b vld=%b data=%h want 0", protoErrA, rspVldA, rspDataA); end
        testsRun++; if (rdCntA !== '0 || wrCntA !== '0) begin failures++; $display("[TB] FAIL async reset counters a: got %0d/%0d want 0/0", rdCntA, wrCntA); end
        clearModel();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'd0, 6'h00, 8'h00, 1'b0);
        testsRun++; if (protoErrB !== 1'b0 || rspVldA !== 1'b0 || rspDataB !== '0) begin failures++; $display("[TB] FAIL after reset: got err=%b vld=%b data=%h want 0", protoErrB, rspVldA, rspDataB); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            step(2'd2, AW'(i), 8'(8'h40 + i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step(2'd1, AW'(i), 8'h00, 1'b0);
            testsRun++; if (rspVldB !== expVldB || rspDataB !== expDataB) begin failures++; $display("[TB] FAIL sat read%0d b: got %b/%h want %b/%h", i, rspVldB, rspDataB, expVldB, expDataB); end
        end
        testsRun++; if (rdCntB !== 4'hF || wrCntB !== 4'hF) begin failures++; $display("[TB] FAIL sat counters b: got %h/%h want f/f", rdCntB, wrCntB); end
        testsRun++; if (rdCntA !== expRdA || wrCntA !== expWrA) begin failures++; $display("[TB] FAIL sat counters a: got %0d/%0d want %0d/%0d", rdCntA, wrCntA, expRdA, expWrA); end
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 49) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(op, AW'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 39) == 0));
            testsRun++; if (rspVldA !== expVldA || rspDataA !== expDataA) begin failures++; $display("[TB] FAIL random%0d rsp a: got %b/%h want %b/%h", i, rspVldA, rspDataA, expVldA, expDataA); end
            testsRun++; if (rspVldB !== expVldB || rspDataB !== expDataB) begin failures++; $display("[TB] FAIL random%0d rsp b: got %b/%h want %b/%h", i, rspVldB, rspDataB, expVldB, expDataB); end
            testsRun++; if (rdCntA !== expRdA || wrCntA !== expWrA) begin failures++; $display("[TB] FAIL random%0d cnt a: got %0d/%0d want %0d/%0d", i, rdCntA, wrCntA, expRdA, expWrA); end
            testsRun++; if (rdCntB !== expRdB || wrCntB !== expWrB) begin failures++; $display("[TB] FAIL random%0d cnt b: got %0d/%0d want %0d/%0d", i, rdCntB, wrCntB, expRdB, expWrB); end
            testsRun++; if (protoErrA !== errModel || protoErrB !== errModel) begin failures++; $display("[TB] FAIL random%0d err: got %b/%b want %b", i, protoErrA, protoErrB, errModel); end
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_then_read();
        test_read_then_write();
        test_back_to_back();
        test_bus_rst_flush();
        test_proto_err();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
